// File: rtl/fifo_serializer.sv
// ============================================================================
// Module      : fifo_serializer
// Description : Pops words from a first-word fall-through FIFO read port and
//               shifts each one out as a serial frame: a start bit (0), data
//               LSB first, an optional even-parity bit, and STOP_BITS stop
//               bits (1). Runs entirely in the FIFO read-clock domain.
//
// Parameters  : DATA_W       - word width (must match the FIFO word width)
//               CLKS_PER_BIT - clock cycles per serial bit (>= 1)
//               STOP_BITS    - number of stop bits (1 or 2)
// Macro       : SER_PARITY_EN - when defined, an even-parity bit is inserted
//               between the last data bit and the stop bit(s).
//
// Ports       : i_clk        - clock (FIFO read clock)
//               i_rst        - synchronous active-high reset
//               i_en         - allows a new frame to start
//               i_rdata      - FIFO head word, valid while i_rempty = 0
//               i_rempty     - FIFO empty flag
//               o_rr         - FIFO read request, one pulse per word
//               o_tx         - serial line, idles high
//               o_busy       - high while a frame is in flight
//               o_frame_done - pulse on the last cycle of the last stop bit
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_serializer #(
   parameter int DATA_W       = 32,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic              i_rempty,
   output logic              o_rr,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  c_STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef SER_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   // Counts data bits in DATA, and is reused to count stop bits in STOP.
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q;
   logic                done_q;
   logic                w_baud_last;
   logic                w_stop_end;
   logic                w_pop;
`ifdef SER_PARITY_EN
   logic                parity_q, parity_d;
`endif

   assign w_baud_last = (baud_q == c_BAUD_LAST);
   assign w_stop_end  = (state_q == ST_STOP) && w_baud_last && (bit_q == c_STOP_LAST);

   // Pop from IDLE, or on the final stop cycle so frames run back-to-back.
   assign w_pop = i_en && !i_rempty && !i_rst &&
                  ((state_q == ST_IDLE) || w_stop_end);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
`ifdef SER_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_pop) begin
               state_d  = ST_START;
               baud_d   = '0;
               bit_d    = '0;
               shift_d  = i_rdata;
`ifdef SER_PARITY_EN
               parity_d = ^i_rdata;
`endif
            end
         end
         ST_START: begin
            if (w_baud_last) begin
               state_d = ST_DATA;
               baud_d  = '0;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (w_baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[DATA_W-1:1]};
               if (bit_q == c_BIT_LAST) begin
                  bit_d   = '0;
`ifdef SER_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`ifdef SER_PARITY_EN
         ST_PARITY: begin
            if (w_baud_last) begin
               state_d = ST_STOP;
               baud_d  = '0;
            end else begin
               baud_d  = baud_q + BAUD_W'(1);
            end
         end
`endif
         ST_STOP: begin
            if (w_baud_last) begin
               baud_d = '0;
               if (bit_q == c_STOP_LAST) begin
                  bit_d = '0;
                  if (w_pop) begin
                     state_d  = ST_START;
                     shift_d  = i_rdata;
`ifdef SER_PARITY_EN
                     parity_d = ^i_rdata;
`endif
                  end else begin
                     state_d  = ST_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      // Line value is decoded from the next state so it is registered and
      // changes on the same edge as the state itself.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef SER_PARITY_EN
         ST_PARITY: tx_d = parity_d;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= (state_d == ST_STOP) && (baud_d == c_BAUD_LAST) &&
                     (bit_d == c_STOP_LAST);
`ifdef SER_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign o_rr         = w_pop;
   assign o_tx         = tx_q;
   assign o_busy       = busy_q;
   assign o_frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_serializer.sv
// ============================================================================
// Module      : tb_fifo_serializer
// Description : Self-checking bench for fifo_serializer with a queue-based
//               first-word fall-through FIFO model. Honors SER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_serializer;

   localparam int DW  = 32;
   localparam int CPB = 4;
`ifdef SER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F = (1 + DW + P + 1) * CPB;

   logic          clk = 1'b0;
   logic          i_rst;
   logic          i_en;
   logic [DW-1:0] i_rdata;
   logic          i_rempty;
   logic          o_rr, o_tx, o_busy, o_frame_done;

   fifo_serializer #(
      .DATA_W      (DW),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (1)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_rdata     (i_rdata),
      .i_rempty    (i_rempty),
      .o_rr        (o_rr),
      .o_tx        (o_tx),
      .o_busy      (o_busy),
      .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo[$];
   int            n_chk  = 0;
   int            n_fail = 0;
   int            n_pops = 0;
   logic          s_tx, s_rr, s_busy, s_done;

   typedef struct {
      int   cyc;
      logic en;
      logic tx;
      logic busy;
      logic done;
   } vec_t;

   vec_t vecs[11];

   function automatic void upd_fifo();
      i_rempty = (fifo.size() == 0);
      i_rdata  = (fifo.size() == 0) ? '0 : fifo[0];
   endfunction

   task automatic chk(input string name, input int cyc,
                      input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Sample the current cycle at the falling edge, then let the rising edge
   // consume a word if a read request was active.
   task automatic tick();
      @(negedge clk);
      s_tx   = o_tx;
      s_rr   = o_rr;
      s_busy = o_busy;
      s_done = o_frame_done;
      @(posedge clk);
      if (s_rr && !i_rempty) begin
         void'(fifo.pop_front());
         n_pops++;
      end
      #1;
      upd_fifo();
   endtask

   // Called right after the pop cycle; checks every cycle 1..F of the frame.
   task automatic expect_frame(input logic [DW-1:0] w, input logic next_pop,
                               input int en_drop_at);
      int   slot;
      logic etx;
      for (int c = 1; c <= F; c++) begin
         if (c == en_drop_at) i_en = 1'b0;
         tick();
         slot = (c - 1) / CPB;
         if (slot == 0)                        etx = 1'b0;
         else if (slot <= DW)                  etx = w[slot-1];
         else if (P == 1 && slot == DW + 1)    etx = ^w;
         else                                  etx = 1'b1;
         chk("frame_tx",   c, 32'(s_tx),   32'(etx));
         chk("frame_busy", c, 32'(s_busy), 32'd1);
         chk("frame_done", c, 32'(s_done), 32'(c == F));
         chk("frame_rr",   c, 32'(s_rr),   32'((c == F) && next_pop));
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_en  = 1'b1;
      fifo.push_back(32'hA5A5_0001);
      upd_fifo();

      vecs[0]  = '{1,     1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{4,     1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{5,     1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{8,     1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{9,     1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{12,    1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{132,   1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{133,   1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{F - 1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{F,     1'b1, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{F + 1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset held with data waiting: no pop, line idle.
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_tx",   k, 32'(s_tx),   32'd1);
         chk("rst_rr",   k, 32'(s_rr),   32'd0);
         chk("rst_busy", k, 32'(s_busy), 32'd0);
         chk("rst_done", k, 32'(s_done), 32'd0);
      end
      i_rst = 1'b0;

      // First cycle after reset release pops the waiting word.
      tick();
      chk("post_rst_rr", 0, 32'(s_rr),   32'd1);
      chk("post_rst_tx", 0, 32'(s_tx),   32'd1);
      chk("pop_count",   0, 32'(n_pops), 32'd1);

      // Single word 0xA5A50001 against the vector table.
      for (int c = 1; c <= F + 1; c++) begin
         tick();
         chk("single_rr", c, 32'(s_rr), 32'd0);
         for (int k = 0; k < 11; k++) begin
            if (vecs[k].cyc == c) begin
               chk("vec_tx",   c, 32'(s_tx),   32'(vecs[k].tx));
               chk("vec_busy", c, 32'(s_busy), 32'(vecs[k].busy));
               chk("vec_done", c, 32'(s_done), 32'(vecs[k].done));
            end
         end
      end

      // Two queued words run back-to-back, pops F cycles apart.
      fifo.push_back(32'h0000_0001);
      fifo.push_back(32'h0000_0002);
      upd_fifo();
      tick();
      chk("b2b_first_rr", 0, 32'(s_rr), 32'd1);
      expect_frame(32'h0000_0001, 1'b1, -1);
      expect_frame(32'h0000_0002, 1'b0, -1);
      tick();
      chk("b2b_end_busy",  2 * F + 1, 32'(s_busy),      32'd0);
      chk("b2b_end_tx",    2 * F + 1, 32'(s_tx),        32'd1);
      chk("b2b_end_empty", 2 * F + 1, 32'(i_rempty),    32'd1);
      chk("b2b_pops",      2 * F + 1, 32'(n_pops),      32'd3);

      // i_en dropped mid-frame: frame completes, no further pop until restored.
      fifo.push_back(32'h0000_0007);
      fifo.push_back(32'h0000_0004);
      upd_fifo();
      tick();
      chk("en_first_rr", 0, 32'(s_rr), 32'd1);
      expect_frame(32'h0000_0007, 1'b0, 40);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("en_off_rr",   k, 32'(s_rr),   32'd0);
         chk("en_off_busy", k, 32'(s_busy), 32'd0);
      end
      i_en = 1'b1;
      tick();
      chk("en_restore_rr", 0, 32'(s_rr), 32'd1);
      expect_frame(32'h0000_0004, 1'b0, -1);
      tick();

      // Reset pulsed mid-frame: aborted word dropped, next word sent.
      fifo.push_back(32'h5555_5555);
      fifo.push_back(32'h0F0F_1234);
      upd_fifo();
      tick();
      chk("rstm_first_rr", 0, 32'(s_rr), 32'd1);
      for (int c = 1; c < 50; c++) tick();
      i_rst = 1'b1;
      tick();
      chk("rstm_rr_in_rst", 50, 32'(s_rr), 32'd0);
      i_rst = 1'b0;
      tick();
      chk("rstm_tx",   51, 32'(s_tx),   32'd1);
      chk("rstm_busy", 51, 32'(s_busy), 32'd0);
      chk("rstm_rr",   51, 32'(s_rr),   32'd1);
      expect_frame(32'h0F0F_1234, 1'b0, -1);
      tick();
      chk("rstm_empty", 0, 32'(i_rempty), 32'd1);
      chk("rstm_pops",  0, 32'(n_pops),   32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_serializer.md
# fifo_serializer

Downstream consumer of the `async_fifo` read port. It pops `DATA_W`-bit words from the FIFO and shifts each one out on a single-bit serial line as a framed word: start bit, data LSB first, optional parity, stop bit(s). It runs entirely in the FIFO read-clock domain and forms the TX bit-level stage of the SERDES path.

## Interface
- `DATA_W`, 32: word width; must match the FIFO `LOGIC_SIZE`.
- `CLKS_PER_BIT`, 4: `i_clk` cycles per serial bit; must be ≥ 1.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 or 2.

Ports:
- `i_clk` in 1: single clock; connects to the FIFO `i_rclk`.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: allows a new frame to start; does not abort a frame in flight.
- `i_rdata` in `DATA_W`: FIFO head word, valid whenever `i_rempty`=0.
- `i_rempty` in 1: FIFO empty flag.
- `o_rr` out 1: FIFO read request; a 1-cycle pulse per consumed word.
- `o_tx` out 1: serial line; idles high.
- `o_busy` out 1: high while a frame is in flight.
- `o_frame_done` out 1: 1-cycle pulse on the last cycle of the final stop bit.

## Operation
- **FIFO contract (first-word fall-through):**
  - `i_rdata` already shows the head word while `i_rempty`=0.
  - The word is consumed at the `i_clk` edge where `o_rr`=1 and `i_rempty`=0.
- **`o_rr` decode:** combinational from state, `i_en` and `i_rempty`. It is never asserted while `i_rempty`=1 or during `i_rst`.
- **States:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE:**
  - `o_tx`=1 and `o_busy`=0.
  - If `i_en` && !`i_rempty`: `o_rr`=1, `i_rdata` loads into the shift register, and the next state is START.
- **START:** `o_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- **DATA:**
  - `o_tx` = shift_reg[0], held `CLKS_PER_BIT` cycles per bit, then the register shifts right.
  - A bit counter runs 0..`DATA_W`-1. After bit `DATA_W`-1, go to PARITY if present, else STOP.
- **STOP:** `o_tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. On its last cycle:
  - `o_frame_done`=1.
  - If `i_en` && !`i_rempty`: pop the next word (`o_rr`=1) and go directly to START. Frames run back-to-back with no extra idle cycle.
  - Otherwise go to IDLE.
- **Counters:**
  - Baud counter width is `$clog2(CLKS_PER_BIT)` (minimum 1). With `CLKS_PER_BIT`=1 every state bit lasts exactly one cycle.
  - Bit counter width is `$clog2(DATA_W)`.
  - Both counters wrap to 0 on each bit/state transition.
- **`o_busy`:** 1 in START, DATA, PARITY and STOP.
- **`i_en` behaviour:** deassertion mid-frame has no effect on the current frame. It only blocks the next pop.

## Timing
- **Reset values:** `o_tx`=1, `o_rr`=0, `o_busy`=0, `o_frame_done`=0. State returns to IDLE and both counters to 0.
- **Reset mid-frame:**
  - `o_tx`=1 on the cycle after the `i_rst` edge.
  - The partially sent word is dropped and is not re-popped.
  - No `o_rr` is issued while `i_rst`=1.
- **Pop-to-line latency:** `o_tx` falls on the cycle after the `o_rr` edge, registered from state.
- **Frame length:** F = (1 + `DATA_W` + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P = 1 with parity, else 0.
  - Defaults without parity: 34 × 4 = 136 cycles.
- **Back-to-back frames:** pops are exactly F cycles apart.
- **Empty/full boundary:** `i_rempty` rising in the same cycle as a would-be pop means no pop, and the FSM goes to IDLE. The block never applies backpressure to the FIFO write side beyond not popping.

## Configuration
- **`SER_PARITY_EN` defined:**
  - The PARITY state is inserted after DATA, lasting `CLKS_PER_BIT` cycles.
  - `o_tx` = XOR of the loaded word (even parity: total ones across data plus parity is even).
  - Frame length grows by `CLKS_PER_BIT`.
- **Not defined:** no parity state or parity logic is generated; STOP follows data bit `DATA_W`-1 directly.

## Test plan
- **Reset with data waiting:** `i_rst`=1 for 3 cycles with `i_rempty`=0 and `i_en`=1 → `o_tx`=1, `o_rr`=0, `o_busy`=0 throughout. First `o_rr` occurs the cycle after `i_rst` drops.
- **Single word 0xA5A5_0001, defaults:**
  - One `o_rr` pulse.
  - `o_tx`=0 for cycles 1–4 after the pop, then 1 for cycles 5–8 (bit0=1), then 0 for cycles 9–12 (bit1).
  - Stop high for cycles 133–136, with `o_frame_done` at cycle 136.
- **Two queued words 0x1 and 0x2:**
  - Exactly 2 `o_rr` pulses, 136 cycles apart.
  - The stop bit of word 1 is followed directly by the start bit of word 2.
  - FIFO ends empty and `o_busy`=0 at cycle 273.
- **`i_en` dropped at cycle 40 of a frame:** the frame completes normally and no further `o_rr` occurs. Restoring `i_en`=1 pops the next word the following cycle.
- **`i_rst` pulsed at cycle 50 of a frame:** `o_tx`=1 on the next cycle. After release, the next FIFO word (not the aborted one) is transmitted.
- **`SER_PARITY_EN` defined, word 0x0000_0007:** the parity bit is 1 and F = 140. Without the macro, the stop bit starts at cycle 133.
